montmult_cios: RTL and testbench
================================

# montmult_cios

Word-serial Montgomery multiplier (CIOS: coarsely integrated operand scanning) computing (a_bar · b_bar · R⁻¹) mod n with R = 2^WIDTH, parametrised in operand width and datapath word size. It is the area-scalable successor to the single-shot full-width Montgomery product: only one WORD×WORD multiplier is used, and inputs and outputs use valid/ready handshakes. It sits under the Paillier exponentiation controller, which issues back-to-back Montgomery products.

## Interface
- WIDTH, 1024: operand/modulus width in bits; R = 2^WIDTH.
- WORD, 64: datapath word width; WIDTH % WORD == 0 and WORD ≥ 8 (elaboration-time check). S = WIDTH/WORD.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block idle and able to accept.
- a_bar  in  WIDTH  Montgomery-domain operand, < n.
- b_bar  in  WIDTH  Montgomery-domain operand, < n.
- n  in  WIDTH  odd modulus.
- n0_prime  in  WORD  −n⁻¹ mod 2^WORD.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  (a_bar·b_bar·R⁻¹) mod n, always < n.

## Operation
- Accept on the rising edge where in_valid && in_ready. Latch a_bar, b_bar, n, and n0_prime. Clear the accumulator t, which is S+2 words. Set the outer index i=0.
- States: IDLE → MUL → MUL_TAIL → RED → RED_TAIL → (MUL with i+1, or SUB when i==S−1) → DONE → IDLE.
- MUL, S cycles, j=0..S−1: (C,S_w) = t[j] + a[j]·b[i] + C; t[j] = S_w. C is cleared at MUL entry.
- MUL_TAIL, 1 cycle: (C,S_w) = t[S] + C; t[S] = S_w; t[S+1] = C.
- RED, S cycles:
  - j=0: m = (t[0]·n0_prime) mod 2^WORD, registered; C = carry of t[0] + m·n[0].
  - j≥1: (C,S_w) = t[j] + m·n[j] + C; t[j−1] = S_w.
- RED_TAIL, 1 cycle: (C,S_w) = t[S] + C; t[S−1] = S_w; t[S] = t[S+1] + C.
- SUB, S cycles: word-serial d = t − n with borrow into a separate WIDTH register.
  - After the last word, result = (t[S] == 1 or no final borrow) ? d : t[S−1:0].
- DONE: out_valid = 1. On out_ready, go to IDLE.
- Width rules:
  - Every (C,S_w) step fits in 2·WORD bits.
  - t < 2n holds at every outer-iteration boundary, so t[S+1] is always 0 after RED_TAIL.
  - m·n[j] is truncated to nothing: the full 2·WORD product is used.
- in_ready = (state == IDLE). in_valid is ignored outside IDLE.
- result and out_valid are held stable while out_valid && !out_ready.
- Inputs a_bar ≥ n or even n are caller errors. Output is unspecified but the FSM must still terminate with the same latency.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, result=0. All internal registers are cleared.
- Latency: out_valid rises exactly L = S·(2S+2) + S + 1 cycles after the accept edge.
  - S=16: L = 561.
  - S=2: L = 15.
- Throughput: in_ready reasserts the cycle after the out_valid && out_ready edge. There is no overlap of consecutive operations.
- Reset asserted in any state: on that edge the block goes to IDLE, out_valid=0, and any partial result is discarded. No out_valid follows.
- in_valid together with rst on the same edge: reset wins and the operand is not accepted.

## Structure
- Package montmult_pkg holds:
  - state_t enum (IDLE, MUL, MUL_TAIL, RED, RED_TAIL, SUB, DONE).
  - function nwords(WIDTH, WORD).
- Sub-module montmult_mac, combinational: out[2·WORD−1:0] = x·y + acc + cin, with all operands WORD bits. One instance serves both MUL and RED; the operand mux is selected by state.
- Word counter j and outer counter i are $clog2(S)+1 bits wide.

## Test plan
All directed cases use WIDTH=16, WORD=8 (S=2, L=15), n=0x8001, n0_prime=0xFF.
- **Identity:** a_bar=0x0001, b_bar=0x7FFF (R mod n) → result=0x0001, out_valid at cycle 15.
- **Zero:** a_bar=0x0000, b_bar=0x1234 → result=0x0000.
- **Montgomery one squared:** a_bar=b_bar=0x7FFF → result=0x7FFF.
- **Max operand:** a_bar=0x8000 (n−1), b_bar=0x7FFF → result=0x8000, with no wrap past n.
- **Backpressure:** out_ready held low 5 cycles after out_valid → result stable and in_ready=0 throughout. in_ready=1 the cycle after the handshake.
- **Reset mid-op:** rst pulsed at cycle 6 after accept → in_ready=1 next cycle and out_valid never rises. A following op (identity case) returns 0x0001 at L=15.
- **Randomised sweep:** WIDTH=1024, WORD=64 against a golden model, including back-to-back ops.

Source files
------------

// File: rtl/montmult_pkg.sv
// Shared types and sizing helpers for the word-serial CIOS Montgomery multiplier.
package montmult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    MUL_TAIL,
    RED,
    RED_TAIL,
    SUB,
    DONE
  } state_t;

  function automatic int nwords(input int width, input int word);
    return width / word;
  endfunction

endpackage

// File: rtl/montmult_mac.sv
// Single WORDxWORD multiply-accumulate: out = x*y + acc + cin, never overflows 2*WORD bits.
module montmult_mac #(
  parameter int WORD = 64
) (
  input  logic [WORD-1:0]   x,
  input  logic [WORD-1:0]   y,
  input  logic [WORD-1:0]   acc,
  input  logic [WORD-1:0]   cin,
  output logic [2*WORD-1:0] out
);

  assign out = {{WORD{1'b0}}, x} * {{WORD{1'b0}}, y}
             + {{WORD{1'b0}}, acc} + {{WORD{1'b0}}, cin};

endmodule

// File: rtl/montmult_cios.sv
// Word-serial CIOS Montgomery product (a_bar*b_bar*R^-1) mod n, R = 2^WIDTH,
// one shared MAC, valid/ready on both sides, one operation in flight.
module montmult_cios
  import montmult_pkg::*;
#(
  parameter int WIDTH = 1024,
  parameter int WORD  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_bar,
  input  logic [WIDTH-1:0] b_bar,
  input  logic [WIDTH-1:0] n,
  input  logic [WORD-1:0]  n0_prime,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int S  = nwords(WIDTH, WORD);
  localparam int CW = $clog2(S) + 1;
  localparam logic [CW-1:0] LAST = CW'(S - 1);

  if (WIDTH % WORD != 0 || WORD < 8) begin : g_bad_params
    $error("montmult_cios: WIDTH must be a multiple of WORD and WORD >= 8");
  end

  state_t            state;
  logic [CW-1:0]     i, j;
  logic [WIDTH-1:0]  a_r, b_r, n_r, d;
  logic [WORD-1:0]   n0p, m, c;
  logic              borrow;
  logic [WORD-1:0]   t [S+2];

  logic [WORD-1:0]   mx, my, macc, mcin, m_new;
  logic [2*WORD-1:0] mac_out;
  logic [WORD-1:0]   mac_lo, mac_hi;
  logic [WORD:0]     sub_w;
  logic [WIDTH-1:0]  t_low;

  assign m_new  = t[0] * n0p;
  assign mac_lo = mac_out[WORD-1:0];
  assign mac_hi = mac_out[2*WORD-1:WORD];
  assign sub_w  = {1'b0, t[j]} - {1'b0, n_r[j*WORD +: WORD]} - {{WORD{1'b0}}, borrow};

  // RED j=0 consumes the freshly computed m; later words use the registered copy.
  always_comb begin
    mx   = '0;
    my   = '0;
    macc = '0;
    mcin = '0;
    case (state)
      MUL: begin
        mx   = a_r[j*WORD +: WORD];
        my   = b_r[i*WORD +: WORD];
        macc = t[j];
        mcin = c;
      end
      MUL_TAIL, RED_TAIL: begin
        macc = t[S];
        mcin = c;
      end
      RED: begin
        mx   = (j == '0) ? m_new : m;
        my   = n_r[j*WORD +: WORD];
        macc = t[j];
        mcin = (j == '0) ? '0 : c;
      end
      default: ;
    endcase
  end

  always_comb begin
    t_low = '0;
    for (int k = 0; k < S; k++) t_low[k*WORD +: WORD] = t[k];
  end

  montmult_mac #(.WORD(WORD)) u_mac (
    .x   (mx),
    .y   (my),
    .acc (macc),
    .cin (mcin),
    .out (mac_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      i         <= '0;
      j         <= '0;
      a_r       <= '0;
      b_r       <= '0;
      n_r       <= '0;
      d         <= '0;
      n0p       <= '0;
      m         <= '0;
      c         <= '0;
      borrow    <= 1'b0;
      for (int k = 0; k < S + 2; k++) t[k] <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r      <= a_bar;
          b_r      <= b_bar;
          n_r      <= n;
          n0p      <= n0_prime;
          for (int k = 0; k < S + 2; k++) t[k] <= '0;
          i        <= '0;
          j        <= '0;
          c        <= '0;
          in_ready <= 1'b0;
          state    <= MUL;
        end
        MUL: begin
          t[j] <= mac_lo;
          c    <= mac_hi;
          if (j == LAST) begin
            j     <= '0;
            state <= MUL_TAIL;
          end else j <= j + 1'b1;
        end
        MUL_TAIL: begin
          t[S]   <= mac_lo;
          t[S+1] <= mac_hi;
          state  <= RED;
        end
        RED: begin
          c <= mac_hi;
          if (j == '0) m <= m_new;
          else t[j - 1'b1] <= mac_lo;
          if (j == LAST) begin
            j     <= '0;
            state <= RED_TAIL;
          end else j <= j + 1'b1;
        end
        RED_TAIL: begin
          t[S-1] <= mac_lo;
          t[S]   <= t[S+1] + mac_hi;
          c      <= '0;
          if (i == LAST) begin
            i      <= '0;
            borrow <= 1'b0;
            state  <= SUB;
          end else begin
            i     <= i + 1'b1;
            state <= MUL;
          end
        end
        SUB: begin
          d[j*WORD +: WORD] <= sub_w[WORD-1:0];
          borrow            <= sub_w[WORD];
          if (j == LAST) begin
            j     <= '0;
            state <= DONE;
          end else j <= j + 1'b1;
        end
        // First DONE cycle picks the reduced value; then hold until consumed.
        DONE: begin
          if (!out_valid) begin
            result    <= (t[S] != '0 || !borrow) ? d : t_low;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_montmult_cios.sv
// Bench: directed 16/8-bit cases plus a randomised 1024/64-bit sweep against a bit-serial model.
module tb_montmult_cios;

  localparam int NRAND = 12;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // small instance: WIDTH=16, WORD=8
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [15:0] s_a, s_b, s_n, s_result;
  logic [7:0]  s_n0p;
  logic [15:0] s_q[$];

  // large instance: WIDTH=1024, WORD=64
  logic          l_in_valid, l_in_ready, l_out_valid, l_out_ready;
  logic [1023:0] l_a, l_b, l_n, l_result;
  logic [63:0]   l_n0p;
  logic [1023:0] l_q[$];
  int            l_t[$];

  montmult_cios #(.WIDTH(16), .WORD(8)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a_bar(s_a), .b_bar(s_b), .n(s_n), .n0_prime(s_n0p),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result)
  );

  montmult_cios #(.WIDTH(1024), .WORD(64)) dut_l (
    .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .a_bar(l_a), .b_bar(l_b), .n(l_n), .n0_prime(l_n0p),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .result(l_result)
  );

  task automatic check_val(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (low 256 bits)", tag, obs[255:0], exp[255:0]);
    end
  endtask

  // Right-to-left binary Montgomery: a*b*2^-1024 mod n.
  function automatic logic [1023:0] mont_ref(input logic [1023:0] a, b, nn);
    logic [1025:0] t;
    t = '0;
    for (int k = 0; k < 1024; k++) begin
      if (a[k]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, nn};
      t = t >> 1;
    end
    if (t >= {2'b00, nn}) t = t - {2'b00, nn};
    return t[1023:0];
  endfunction

  function automatic logic [63:0] neg_inv(input logic [63:0] n0);
    logic [63:0] x;
    x = n0;
    repeat (6) x = x * (64'd2 - n0 * x);
    return -x;
  endfunction

  function automatic logic [1023:0] rand_wide();
    logic [1023:0] r;
    for (int k = 0; k < 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic small_op(input string tag, input logic [15:0] a, b, exp, input int hold);
    int lat;
    lat = 0;
    while (!s_in_ready && lat < 100) begin @(posedge clk); #1; lat++; end
    check_val({tag, "_idle"}, 1024'(s_in_ready), 1024'(1));
    s_a = a;
    s_b = b;
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    s_q.push_back(exp);
    lat = 0;
    while (!s_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check_val({tag, "_lat"}, 1024'(lat), 1024'(15));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_val({tag, "_hold_res"}, 1024'(s_result), 1024'(s_q[0]));
      check_val({tag, "_hold_vld"}, 1024'(s_out_valid), 1024'(1));
      check_val({tag, "_hold_rdy"}, 1024'(s_in_ready), 1024'(0));
    end
    s_out_ready = 1'b1;
    check_val({tag, "_res"}, 1024'(s_result), 1024'(s_q.pop_front()));
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    check_val({tag, "_rdy_after"}, 1024'(s_in_ready), 1024'(1));
    check_val({tag, "_vld_after"}, 1024'(s_out_valid), 1024'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1;
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    s_a = '0; s_b = '0; s_n = 16'h8001; s_n0p = 8'hFF;
    l_in_valid = 1'b0; l_out_ready = 1'b0;
    l_a = '0; l_b = '0; l_n = '0; l_n0p = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_s_in_ready", 1024'(s_in_ready), 1024'(1));
    check_val("rst_s_out_valid", 1024'(s_out_valid), 1024'(0));
    check_val("rst_s_result", 1024'(s_result), 1024'(0));
    check_val("rst_l_in_ready", 1024'(l_in_ready), 1024'(1));
    check_val("rst_l_out_valid", 1024'(l_out_valid), 1024'(0));
    check_val("rst_l_result", l_result, 1024'(0));

    small_op("identity", 16'h0001, 16'h7FFF, 16'h0001, 0);
    small_op("zero", 16'h0000, 16'h1234, 16'h0000, 0);
    small_op("one_sq", 16'h7FFF, 16'h7FFF, 16'h7FFF, 0);
    small_op("max_op", 16'h8000, 16'h7FFF, 16'h8000, 0);
    small_op("backpr", 16'h7FFF, 16'h7FFF, 16'h7FFF, 5);

    // in_valid coincident with reset must not be accepted
    s_a = 16'h0001; s_b = 16'h7FFF;
    s_in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; s_in_valid = 1'b0;
    @(posedge clk); #1;
    check_val("rst_vs_valid_rdy", 1024'(s_in_ready), 1024'(1));

    // reset in the middle of an operation
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    s_q.push_back(16'h0001);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    s_q.delete();
    check_val("midrst_rdy", 1024'(s_in_ready), 1024'(1));
    check_val("midrst_vld", 1024'(s_out_valid), 1024'(0));
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (s_out_valid) seen = 1; end
    check_val("midrst_no_out", 1024'(seen), 1024'(0));
    small_op("post_rst", 16'h0001, 16'h7FFF, 16'h0001, 0);

    fork
      begin : driver
        logic [1023:0] na, aa, bb;
        logic acc;
        int wd;
        for (int k = 0; k < NRAND; k++) begin
          na = rand_wide();
          na[1023] = 1'b1;
          na[0] = 1'b1;
          aa = rand_wide();
          bb = rand_wide();
          aa[1023] = 1'b0;
          bb[1023] = 1'b0;
          if (k == 3) begin
            aa = na - 1024'(1);
            bb = na - 1024'(1);
          end
          l_n = na; l_a = aa; l_b = bb; l_n0p = neg_inv(na[63:0]);
          l_in_valid = 1'b1;
          acc = 1'b0;
          wd = 0;
          while (!acc && wd < 3000) begin
            acc = l_in_ready;
            @(posedge clk); #1;
            wd++;
          end
          if (!acc) check_val("l_accept", 1024'(acc), 1024'(1));
          else begin
            l_q.push_back(mont_ref(aa, bb, na));
            l_t.push_back(cyc);
          end
        end
        l_in_valid = 1'b0;
      end
      begin : monitor
        int got, wd;
        logic prev, hs;
        got = 0; wd = 0; prev = 1'b0;
        while (got < NRAND && wd < NRAND * 800) begin
          if (l_out_valid && !prev) check_val("l_lat", 1024'(cyc - l_t[0]), 1024'(561));
          prev = l_out_valid;
          l_out_ready = ($urandom_range(0, 3) != 0);
          hs = l_out_valid && l_out_ready;
          if (hs) begin
            check_val("l_result", l_result, l_q.pop_front());
            void'(l_t.pop_front());
            got++;
          end
          @(posedge clk); #1;
          wd++;
        end
        l_out_ready = 1'b0;
        if (got < NRAND) check_val("l_count", 1024'(got), 1024'(NRAND));
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
